// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the condition-code path and its neighbours.
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_nzp;

    localparam lc3b_nzp CC_RESET_VAL = 3'b010;

    localparam int CC_CNT_W = 4;
    typedef logic [CC_CNT_W-1:0] lc3b_cc_cnt;
endpackage

// File: rtl/nzp_gen.sv
// Combinational n/z/p derivation from a result word; always yields a one-hot code.
module nzp_gen
    import lc3b_types::*;
(
    input  lc3b_word data_i,
    output lc3b_nzp  nzp_o
);
    logic n, z;

    assign n     = data_i[15];
    assign z     = (data_i == 16'h0000);
    assign nzp_o = {n, z, !n && !z};
endmodule

// File: rtl/cc_reg_unit.sv
// Condition-code producer: one-deep writeback stage feeding nzp_cc, plus a
// saturating count of in-flight CC writers so decode can stall dependent branches.
module cc_reg_unit
    import lc3b_types::*;
#(
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [15:0]      wb_data,
    input  logic             wb_load_cc,
    input  logic             cc_hold,
    output logic [2:0]       nzp_cc,
    output logic             cc_pending,
    output logic [CNT_W-1:0] pending_count,
    output logic             err
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

    logic             stage_full_q, stage_full_d;
    lc3b_word         stage_q, stage_d;
    lc3b_nzp          nzp_q, nzp_d, stage_nzp;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             xfer, load, commit;

    nzp_gen u_nzp_gen (
        .data_i (stage_q),
        .nzp_o  (stage_nzp)
    );

    // An empty stage can still absorb one result while the branch holds CC.
    assign wb_ready = !stage_full_q || !cc_hold;
    assign xfer     = wb_valid && wb_ready;
    assign load     = xfer && wb_load_cc;
    assign commit   = stage_full_q && !cc_hold;

    always_comb begin
        stage_full_d = stage_full_q;
        stage_d      = stage_q;
        nzp_d        = nzp_q;
        cnt_d        = cnt_q;
        err_d        = err_q;

        if (commit) begin
            nzp_d        = stage_nzp;
            stage_full_d = 1'b0;
        end
        if (load) begin
            stage_d      = wb_data;
            stage_full_d = 1'b1;
        end

        case ({alloc, commit})
            2'b10: begin
                if (cnt_q == MAX_CNT) err_d = 1'b1;
                else                  cnt_d = cnt_q + 1'b1;
            end
            2'b01: begin
                if (cnt_q == '0) err_d = 1'b1;
                else             cnt_d = cnt_q - 1'b1;
            end
            default: ;
        endcase

        pend_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_full_q <= 1'b0;
            stage_q      <= '0;
            nzp_q        <= CC_RESET_VAL;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            stage_full_q <= stage_full_d;
            stage_q      <= stage_d;
            nzp_q        <= nzp_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            err_q        <= err_d;
        end
    end

    assign nzp_cc        = nzp_q;
    assign cc_pending    = pend_q;
    assign pending_count = cnt_q;
    assign err           = err_q;
endmodule

// File: tb/tb_cc_reg_unit.sv
// Directed bench for cc_reg_unit: handshake, latency, hold, counter saturation and reset.
module tb_cc_reg_unit;
    logic        clk = 1'b0;
    logic        reset, alloc, wb_valid, wb_load_cc, cc_hold;
    logic [15:0] wb_data;
    logic        wb_ready, cc_pending, err;
    logic [2:0]  nzp_cc;
    logic [3:0]  pending_count;

    int total = 0;
    int bad   = 0;

    cc_reg_unit #(.MAX_PENDING(4), .CNT_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .alloc         (alloc),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_data       (wb_data),
        .wb_load_cc    (wb_load_cc),
        .cc_hold       (cc_hold),
        .nzp_cc        (nzp_cc),
        .cc_pending    (cc_pending),
        .pending_count (pending_count),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic [15:0] d);
        wb_valid   = 1'b1;
        wb_load_cc = 1'b1;
        wb_data    = d;
    endtask

    task automatic idle();
        wb_valid   = 1'b0;
        wb_load_cc = 1'b0;
        wb_data    = 16'hDEAD;
    endtask

    initial begin
        reset = 1'b1; alloc = 1'b0; cc_hold = 1'b0;
        idle();
        step(); step();
        reset = 1'b0;
        step(); step(); step();
        chk("rst_nzp",   16'(nzp_cc), 16'h2);
        chk("rst_pend",  16'(cc_pending), 16'h0);
        chk("rst_cnt",   16'(pending_count), 16'h0);
        chk("rst_err",   16'(err), 16'h0);
        chk("rst_ready", 16'(wb_ready), 16'h1);

        // back-to-back stream; commits here happen with count 0, so err sets
        wb(16'h8000); step();
        chk("str_lat1", 16'(nzp_cc), 16'h2);
        wb(16'h0000); step();
        chk("str_n", 16'(nzp_cc), 16'h4);
        wb(16'h0001); step();
        chk("str_z", 16'(nzp_cc), 16'h2);
        idle(); step();
        chk("str_p", 16'(nzp_cc), 16'h1);
        chk("str_err_underflow", 16'(err), 16'h1);
        chk("str_cnt_hold0", 16'(pending_count), 16'h0);

        reset = 1'b1; step(); reset = 1'b0;
        chk("rst2_err", 16'(err), 16'h0);

        // pending count up then down
        alloc = 1'b1; step();
        chk("pend_cnt1", 16'(pending_count), 16'h1);
        chk("pend_flag1", 16'(cc_pending), 16'h1);
        step();
        chk("pend_cnt2", 16'(pending_count), 16'h2);
        alloc = 1'b0;
        wb(16'h8001); step();
        chk("pend_cnt2b", 16'(pending_count), 16'h2);
        wb(16'h7FFF); step();
        chk("pend_cnt_c1", 16'(pending_count), 16'h1);
        chk("pend_nzp_c1", 16'(nzp_cc), 16'h4);
        idle(); step();
        chk("pend_cnt_c0", 16'(pending_count), 16'h0);
        chk("pend_flag0", 16'(cc_pending), 16'h0);
        chk("pend_nzp_c0", 16'(nzp_cc), 16'h1);
        chk("pend_err", 16'(err), 16'h0);

        // hold with a full stage
        alloc = 1'b1; step(); step(); alloc = 1'b0;
        wb(16'hFFFF); step();
        cc_hold = 1'b1;
        wb(16'h0005); #1;
        chk("hold_ready", 16'(wb_ready), 16'h0);
        step();
        chk("hold_nzp", 16'(nzp_cc), 16'h1);
        step();
        chk("hold_nzp2", 16'(nzp_cc), 16'h1);
        chk("hold_cnt", 16'(pending_count), 16'h2);
        cc_hold = 1'b0; #1;
        chk("unhold_ready", 16'(wb_ready), 16'h1);
        step();
        chk("unhold_nzp_n", 16'(nzp_cc), 16'h4);
        idle(); step();
        chk("unhold_nzp_p", 16'(nzp_cc), 16'h1);
        chk("unhold_cnt", 16'(pending_count), 16'h0);
        chk("unhold_err", 16'(err), 16'h0);

        // hold with empty stage still accepts one
        cc_hold = 1'b1;
        wb(16'h0000); #1;
        chk("hold_empty_ready", 16'(wb_ready), 16'h1);
        step(); #1;
        chk("hold_full_ready", 16'(wb_ready), 16'h0);
        idle(); cc_hold = 1'b0;
        alloc = 1'b1; step(); alloc = 1'b0;
        chk("hold_empty_commit", 16'(nzp_cc), 16'h2);
        chk("alloc_commit_same", 16'(pending_count), 16'h0);

        // saturation
        alloc = 1'b1;
        step(); step(); step(); step();
        chk("sat_cnt4", 16'(pending_count), 16'h4);
        chk("sat_err0", 16'(err), 16'h0);
        step();
        alloc = 1'b0;
        chk("sat_cnt_hold", 16'(pending_count), 16'h4);
        chk("sat_err1", 16'(err), 16'h1);
        wb(16'h0001); step(); step(); step(); step();
        idle(); step();
        chk("drain_cnt", 16'(pending_count), 16'h0);
        chk("drain_pend", 16'(cc_pending), 16'h0);
        wb(16'h8000); step(); idle(); step();
        chk("under_cnt", 16'(pending_count), 16'h0);
        chk("under_err", 16'(err), 16'h1);
        chk("under_nzp", 16'(nzp_cc), 16'h4);

        // reset discards a full stage
        alloc = 1'b1; step(); step(); step(); alloc = 1'b0;
        chk("pre_rst_cnt", 16'(pending_count), 16'h3);
        wb(16'h0001); step();
        idle(); reset = 1'b1; step(); reset = 1'b0;
        chk("mid_rst_nzp", 16'(nzp_cc), 16'h2);
        chk("mid_rst_cnt", 16'(pending_count), 16'h0);
        chk("mid_rst_err", 16'(err), 16'h0);
        step(); step();
        chk("discard_nzp", 16'(nzp_cc), 16'h2);

        // transfer without load_cc is dropped
        wb_valid = 1'b1; wb_load_cc = 1'b0; wb_data = 16'h8000; #1;
        chk("noload_ready", 16'(wb_ready), 16'h1);
        step(); idle(); step(); step();
        chk("noload_nzp", 16'(nzp_cc), 16'h2);
        chk("noload_err", 16'(err), 16'h0);
        chk("noload_cnt", 16'(pending_count), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
